// File: rtl/cpu_selftest_seq.sv
// On-chip self-test sequencer: replays a programmed checkpoint table against the cpu core,
// driving SW, waiting, then comparing LED/PC and recording pass/fail and the first failure.
module cpu_selftest_seq #(
  parameter int DATA_W       = 8,
  parameter int PC_W         = 6,
  parameter int SW_W         = 9,
  parameter int DEPTH        = 16,
  parameter int CYC_W        = 8,
  parameter int STOP_ON_FAIL = 0,
  parameter logic [SW_W-1:0] SW_RESET = '0,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int ENTRY_W = CYC_W + SW_W + DATA_W + PC_W + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_wdata,
  input  logic [ADDR_W:0]    cfg_count,
  input  logic               start,
  input  logic [DATA_W-1:0]  led_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic [SW_W-1:0]    sw_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDR_W:0]    err_count,
  output logic               fail_valid,
  output logic [ADDR_W-1:0]  fail_idx,
  output logic [DATA_W-1:0]  fail_led,
  output logic [PC_W-1:0]    fail_pc
);

  localparam int SW_LO   = CYC_W;
  localparam int ELED_LO = SW_LO + SW_W;
  localparam int EPC_LO  = ELED_LO + DATA_W;
  localparam int CHK_LED = EPC_LO + PC_W;
  localparam int CHK_PC  = CHK_LED + 1;

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t             state;
  logic [ENTRY_W-1:0] tbl [DEPTH];
  logic [ENTRY_W-1:0] cur;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W:0]    idx_inc;
  logic [ADDR_W:0]    n_q;
  logic [ADDR_W:0]    n_lat;
  logic [ADDR_W:0]    err_inc;
  logic [CYC_W-1:0]   cnt;
  logic               mismatch;
  logic               tbl_we;
  logic               idle_like;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign tbl_we    = cfg_we && idle_like && ({1'b0, cfg_addr} < (ADDR_W+1)'(DEPTH));
  assign cur       = tbl[idx];
  assign idx_inc   = {1'b0, idx} + (ADDR_W+1)'(1);
  assign n_lat     = (cfg_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : cfg_count;
  assign err_inc   = (&err_count) ? err_count : err_count + (ADDR_W+1)'(1);

  always_comb begin
    mismatch = 1'b0;
    if (cur[CHK_LED] && (led_in != cur[ELED_LO +: DATA_W])) mismatch = 1'b1;
    if (cur[CHK_PC]  && (pc_in  != cur[EPC_LO  +: PC_W]))   mismatch = 1'b1;
  end

  // Table contents survive reset so a reset-abort can be followed by a rerun.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[cfg_addr] <= cfg_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sw_out     <= SW_RESET;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      fail_led   <= '0;
      fail_pc    <= '0;
      idx        <= '0;
      n_q        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            fail_led   <= '0;
            fail_pc    <= '0;
            idx        <= '0;
            n_q        <= n_lat;
            if (n_lat == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_APPLY;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        S_APPLY: begin
          sw_out <= cur[SW_LO +: SW_W];
          cnt    <= cur[CYC_W-1:0];
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_CHECK;
          else           cnt   <= cnt - CYC_W'(1);
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_inc;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
              fail_led   <= led_in;
              fail_pc    <= pc_in;
            end
          end
          // pass uses this cycle's result since err_count updates on the same edge.
          if ((mismatch && (STOP_ON_FAIL != 0)) || (idx_inc == n_q)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_count == '0);
          end else begin
            idx   <= idx_inc[ADDR_W-1:0];
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_selftest_seq.sv
// Directed bench for cpu_selftest_seq with a small multicycle cpu stub
// (LDI/LDI/OUT R1/OUT R2/BRANCH, one instruction every two cycles).
module tb_cpu_selftest_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [32:0] cfg_wdata = '0;
  logic [4:0]  cfg_count = '0;
  logic        start = 1'b0;
  logic        cpu_rst = 1'b1;

  logic [8:0] sw0, sw1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
  logic [4:0] err0, err1;
  logic [3:0] fidx0, fidx1;
  logic [7:0] fled0, fled1;
  logic [5:0] fpc0, fpc1;

  logic [5:0] cpu_pc = '0;
  logic [7:0] cpu_led = '0, r1 = '0, r2 = '0;
  logic       ph = 1'b0;

  int checks = 0;
  int errors = 0;
  int k;
  logic [8:0] log_sw [0:300];
  logic       log_d1 [0:300];

  always #5 clk = ~clk;

  cpu_selftest_seq #(.SW_RESET(9'h0A5)) dut0 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_count(cfg_count), .start(start), .led_in(cpu_led), .pc_in(cpu_pc),
    .sw_out(sw0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_idx(fidx0), .fail_led(fled0), .fail_pc(fpc0));

  cpu_selftest_seq #(.STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_count(cfg_count), .start(start), .led_in(cpu_led), .pc_in(cpu_pc),
    .sw_out(sw1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_idx(fidx1), .fail_led(fled1), .fail_pc(fpc1));

  always @(posedge clk) begin
    if (cpu_rst) begin
      cpu_pc <= '0; cpu_led <= '0; r1 <= '0; r2 <= '0; ph <= 1'b0;
    end else begin
      ph <= ~ph;
      if (ph) begin
        case (cpu_pc)
          6'd0: begin r1 <= 8'hAA; cpu_pc <= 6'd1; end
          6'd1: begin r2 <= 8'hBB; cpu_pc <= 6'd2; end
          6'd2: begin cpu_led <= r1; cpu_pc <= 6'd3; end
          6'd3: begin cpu_led <= r2; cpu_pc <= 6'd4; end
          6'd4: if (sw0[8]) cpu_pc <= 6'd5;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [32:0] ent(input logic cpc, input logic cled, input logic [5:0] epc,
                                      input logic [7:0] eled, input logic [8:0] sw, input logic [7:0] w);
    return {cpc, cled, epc, eled, sw, w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [32:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // k counts negedges after start was raised; k=1 is the first APPLY cycle.
  task automatic run(input logic [4:0] count, input int rst_k, input int wr_k,
                     input logic [32:0] wd, output int kk);
    logic fin;
    fin = 1'b0;
    cfg_count = count;
    @(negedge clk);
    start = 1'b1; cpu_rst = 1'b1; kk = 0;
    while (!fin && kk < 300) begin
      @(negedge clk);
      kk++;
      start = 1'b0; cpu_rst = 1'b0; cfg_we = 1'b0;
      log_sw[kk] = sw0;
      log_d1[kk] = done1;
      if (kk == wr_k) begin cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = wd; end
      if (kk == rst_k) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fin = 1'b1;
      end else if (done0) begin
        fin = 1'b1;
      end
    end
    if (!fin) chk("run_timeout", 32'd1, 32'd0);
    cfg_we = 1'b0;
  endtask

  logic [32:0] e0, e1, e1bad, e2, e2bad, e3, fill;

  initial begin
    e0    = ent(1'b0, 1'b1, 6'h00, 8'hAA, 9'h000, 8'd4);
    e1    = ent(1'b0, 1'b1, 6'h00, 8'hBB, 9'h000, 8'd0);
    e1bad = ent(1'b0, 1'b1, 6'h00, 8'hCC, 9'h000, 8'd0);
    e2    = ent(1'b1, 1'b0, 6'h04, 8'h00, 9'h000, 8'd0);
    e2bad = ent(1'b1, 1'b0, 6'h07, 8'h00, 9'h055, 8'd0);
    e3    = ent(1'b1, 1'b0, 6'h05, 8'h00, 9'h100, 8'd4);
    fill  = ent(1'b0, 1'b0, 6'h00, 8'h00, 9'h000, 8'd0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_sw", 32'(sw0), 32'h0A5);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_pass", 32'(pass0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_fv", 32'(fv0), 0);
    chk("rst_sw1", 32'(sw1), 0);

    wr(4'd0, e0); wr(4'd1, e1); wr(4'd2, e2); wr(4'd3, e3);
    for (int i = 4; i < 16; i++) wr(4'(i), fill);

    // N=3 basic program: 7+3+3 cycles, done visible at k=14
    run(5'd3, -1, -1, '0, k);
    chk("n3_cycles", k, 14);
    chk("n3_pass", 32'(pass0), 1);
    chk("n3_err", 32'(err0), 0);
    chk("n3_fv", 32'(fv0), 0);

    // N=4 with branch entry: sw 0x100 visible one cycle after entry 3 APPLY (k=14)
    run(5'd4, -1, -1, '0, k);
    chk("n4_cycles", k, 21);
    chk("n4_sw_at_apply", 32'(log_sw[14]), 0);
    chk("n4_sw_after_apply", 32'(log_sw[15]), 32'h100);
    chk("n4_pass", 32'(pass0), 1);
    chk("n4_pass1", 32'(pass1), 1);

    // entry 1 corrupted, no stop: all 4 entries run
    wr(4'd1, e1bad);
    run(5'd4, -1, -1, '0, k);
    chk("c1_cycles", k, 21);
    chk("c1_err", 32'(err0), 1);
    chk("c1_fv", 32'(fv0), 1);
    chk("c1_fidx", 32'(fidx0), 1);
    chk("c1_fled", 32'(fled0), 32'hBB);
    chk("c1_fpc", 32'(fpc0), 4);
    chk("c1_pass", 32'(pass0), 0);
    chk("c1_done", 32'(done0), 1);

    // entries 1 and 2 corrupted; stop-on-fail instance halts after entry 1 CHECK (k=10)
    wr(4'd2, e2bad);
    run(5'd4, -1, -1, '0, k);
    chk("s_done1_early", 32'(log_d1[10]), 0);
    chk("s_done1_edge", 32'(log_d1[11]), 1);
    chk("s_err1", 32'(err1), 1);
    chk("s_fidx1", 32'(fidx1), 1);
    chk("s_sw1", 32'(sw1), 0);
    chk("s_pass1", 32'(pass1), 0);
    chk("s_err0", 32'(err0), 2);
    chk("s_fidx0", 32'(fidx0), 1);

    wr(4'd2, e2);
    run(5'd0, -1, -1, '0, k);
    chk("n0_cycles", k, 1);
    chk("n0_pass", 32'(pass0), 1);
    chk("n0_err", 32'(err0), 0);

    // entry 1 still corrupted; reset lands in WAIT of entry 2
    run(5'd4, 12, -1, '0, k);
    chk("mr_sw", 32'(sw0), 32'h0A5);
    chk("mr_busy", 32'(busy0), 0);
    chk("mr_done", 32'(done0), 0);
    chk("mr_pass", 32'(pass0), 0);
    chk("mr_err", 32'(err0), 0);
    chk("mr_fv", 32'(fv0), 0);
    chk("mr_fidx", 32'(fidx0), 0);
    chk("mr_fled", 32'(fled0), 0);
    chk("mr_fpc", 32'(fpc0), 0);
    chk("mr_done1", 32'(done1), 0);
    chk("mr_err1", 32'(err1), 0);

    wr(4'd1, e1);
    run(5'd19, -1, -1, '0, k);
    chk("ovf_cycles", k, 57);
    chk("ovf_pass", 32'(pass0), 1);

    // write during busy must be dropped
    run(5'd4, -1, 5, e1bad, k);
    chk("wb_pass", 32'(pass0), 1);
    run(5'd4, -1, -1, '0, k);
    chk("wb_rerun_pass", 32'(pass0), 1);
    chk("wb_rerun_err", 32'(err0), 0);
    chk("wb_rerun_cycles", k, 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_selftest_seq.md
# cpu_selftest_seq

Parametrised, synthesisable on-chip self-test sequencer for the `cpu` core. It replays a programmable table of checkpoints against the CPU. Each checkpoint drives the switch inputs, waits a programmed number of cycles, then compares the LED and PC outputs against expected values. It records pass/fail, an error count and the first failure, so the same checks run in simulation and on the FPGA without a behavioural bench.

## Interface
Parameters:
- `DATA_W`, 8: LED/data width.
- `PC_W`, 6: PC width.
- `SW_W`, 9: switch width (bit `SW_W-1` is the branch-condition switch).
- `DEPTH`, 16: number of table entries (≥2); `ADDR_W = $clog2(DEPTH)`.
- `CYC_W`, 8: wait-field width.
- `STOP_ON_FAIL`, 0: when 1, stop at the first mismatch.
- `SW_RESET`, 0: `sw_out` value at reset.

Entry format (`ENTRY_W = CYC_W+SW_W+DATA_W+PC_W+2`), MSB first: `{chk_pc, chk_led, exp_pc, exp_led, sw, wait}`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  ADDR_W  table write address.
- `cfg_wdata`  in  ENTRY_W  table write data.
- `cfg_count`  in  ADDR_W+1  number of entries to run; latched at start.
- `start`  in  1  run request, level sampled per cycle.
- `led_in`  in  DATA_W  from CPU `LED`.
- `pc_in`  in  PC_W  from CPU `pc`.
- `sw_out`  out  SW_W  to CPU `SW`, registered.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished, held.
- `pass`  out  1  valid when `done`; 1 iff `err_count==0`.
- `err_count`  out  ADDR_W+1  mismatching entries, saturating.
- `fail_valid`  out  1  a first failure has been captured.
- `fail_idx`  out  ADDR_W  index of the first failing entry.
- `fail_led`  out  DATA_W  `led_in` at the first failure.
- `fail_pc`  out  PC_W  `pc_in` at the first failure.

## Operation
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- Table is a DEPTH×ENTRY_W register array and is not reset.
  - Writes are accepted only in IDLE/DONE.
  - Writes with `cfg_addr ≥ DEPTH` are ignored.
  - `cfg_we` while `busy` is ignored.
- IDLE/DONE + `start=1`:
  - clear `err_count`, `fail_*`, `done`, `pass`; latch `N = min(cfg_count, DEPTH)`; set `idx=0`.
  - If `N==0`: go to DONE with `pass=1`.
  - Else: go to APPLY.
- APPLY: `sw_out <= entry[idx].sw`; `cnt <= entry[idx].wait`; go to WAIT.
- WAIT: if `cnt==0` go to CHECK, else `cnt--`.
- CHECK: compare the current-cycle `led_in`/`pc_in` with the expected fields, gated by `chk_led`/`chk_pc`. With both flags 0 the entry never mismatches, so it is only a stimulus/delay step.
- Mismatch handling:
  - `err_count` increments, saturating at all-ones.
  - If `fail_valid==0`, capture `idx`, `led_in`, `pc_in` and set `fail_valid`.
  - If `STOP_ON_FAIL`, go to DONE.
- After CHECK: if `idx==N-1` go to DONE, else `idx++` and go to APPLY.
- DONE: `done=1`, `pass=(err_count==0)`. Held until the next `start`.
- `sw_out` keeps its last value in IDLE/DONE.
- `start` while `busy` is ignored.
- `busy=1` in APPLY/WAIT/CHECK.

## Timing
- Reset values: state IDLE, `sw_out=SW_RESET`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `fail_valid=0`, `fail_idx/led/pc=0`.
- Reset mid-run aborts immediately, with the same values as above.
- Cycle numbering: APPLY is in cycle t0.
  - `sw_out` is valid from t0+1.
  - WAIT occupies t0+1 … t0+1+W.
  - CHECK samples the inputs in cycle t0+W+2.
  - Results are registered at the end of that cycle.
  - The next APPLY is at t0+W+3.
- Per-entry period: W+3 cycles.
- First APPLY occurs the cycle after `start` is sampled.
- `done` rises the cycle after the last CHECK.
- W=0 is legal: a 3-cycle entry.
- W=2^CYC_W−1 is legal: no wrap, counts down fully.
- Entry `sw` takes effect even if it equals the previous value; no glitch, since `sw_out` is registered.

## Test plan
- CPU program LDI/LDI/OUT R1/OUT R2/BRANCH with N=3:
  - Entry 0: {wait=4, sw=0x000, exp_led=0xAA, chk_led}.
  - Entry 1: {wait=0, exp_led=0xBB, chk_led}.
  - Entry 2: {wait=0, exp_pc=0x04, chk_pc}.
  - Required: `done=1`, `pass=1`, `err_count=0`.
- Same program, add entry 3: {wait=4, sw=0x100, exp_pc=0x05, chk_pc}, N=4. Required: `sw_out==0x100` one cycle after APPLY; `pass=1`.
- Corrupt entry 1 to `exp_led=0xCC`, `STOP_ON_FAIL=0`, N=4. Required: `err_count=1`, `fail_idx=1`, `fail_led=0xBB`, `pass=0`, and all 4 entries executed.
- `STOP_ON_FAIL=1` with entries 1 and 2 corrupted. Required: `done` asserts one cycle after CHECK of entry 1; `err_count=1`; `sw_out` not updated to entry 2's value.
- `cfg_count=0` gives `done=1`, `pass=1` one cycle after start. `cfg_count=DEPTH+3` runs exactly DEPTH entries.
- Assert `reset` during WAIT of entry 2, then release. Required: all outputs at reset values. `cfg_we` during `busy` leaves the table unchanged, verified by rerun.
